// File: rtl/gpu_fg_pkg.sv
// Shared types and constants for the foreground (sprite) engine.
package gpu_fg_pkg;

    localparam logic [11:0] PMF_BASE = 12'h000;
    localparam logic [11:0] OBM_BASE = 12'h800;

    typedef struct packed {
        logic        valid;
        logic [7:0]  x;
        logic [15:0] line;
        logic [2:0]  colour;
    } fg_slot_t;

    typedef enum logic [1:0] {IDLE, SCAN, FETCH} fg_state_t;

    // Mirror a pattern row horizontally: 2-bit pixel pairs swap end for end.
    function automatic logic [15:0] pair_reverse(input logic [15:0] v);
        logic [15:0] o;
        for (int i = 0; i < 8; i++) begin
            o[2*i +: 2] = v[14-2*i +: 2];
        end
        return o;
    endfunction

endpackage

// File: rtl/foreground_slot_mixer.sv
// Per-slot horizontal hit test and lowest-index-wins pixel selection.
module foreground_slot_mixer
    import gpu_fg_pkg::*;
#(
    parameter int MAX_PER_LINE = 8
)(
    input  logic [7:0] current_x,
    input  fg_slot_t   slots [MAX_PER_LINE],
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       valid
);

    logic [8:0]              dx  [MAX_PER_LINE];
    logic [1:0]              pix [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] opaque;

    always_comb begin
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            dx[i]     = {1'b0, current_x} - {1'b0, slots[i].x};
            pix[i]    = slots[i].line[{3'd7 - dx[i][2:0], 1'b0} +: 2];
            opaque[i] = slots[i].valid && (dx[i] < 9'd8) && (pix[i] != 2'b00);
        end
    end

    // Walk from the top so the lowest opaque slot is the last writer.
    always_comb begin
        r     = 2'b00;
        g     = 2'b00;
        b     = 2'b00;
        valid = 1'b0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                r     = pix[i] & {2{slots[i].colour[2]}};
                g     = pix[i] & {2{slots[i].colour[1]}};
                b     = pix[i] & {2{slots[i].colour[0]}};
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/foreground_scanline.sv
// Foreground engine: evaluates the next line into a build bank while the active bank renders.
//   state | meaning
//   IDLE  | waiting for line_start
//   SCAN  | one object per cycle, record hits into build-bank slots
//   FETCH | one PMF row read per recorded slot, data lands a cycle later
module foreground_scanline
    import gpu_fg_pkg::*;
#(
    parameter int NUM_OBJECTS     = 64,
    parameter int MAX_PER_LINE    = 8,
    parameter int NUM_PATTERNS    = 32,
    parameter int VRAM_ADDR_WIDTH = 12
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 current_x,
    input  logic [7:0]                 current_y,
    input  logic                       line_start,
    input  logic                       writable,
    input  logic [7:0]                 data_in,
    input  logic [VRAM_ADDR_WIDTH-1:0] address,
    input  logic                       write_enable,
    output logic [1:0]                 r,
    output logic [1:0]                 g,
    output logic [1:0]                 b,
    output logic                       valid,
    output logic                       busy,
    output logic                       sprite_overflow
);

    localparam int OBJ_W     = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1;
    localparam int SLOT_W    = $clog2(MAX_PER_LINE + 1);
    localparam int SI_W      = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int PAT_W     = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int PMF_WORDS = NUM_PATTERNS * 8;

    logic [7:0] obm_x [NUM_OBJECTS];
    logic [7:0] obm_y [NUM_OBJECTS];
    logic [6:0] obm_a [NUM_OBJECTS];
    logic [2:0] obm_c [NUM_OBJECTS];
    logic [7:0] pmf_hi [PMF_WORDS];
    logic [7:0] pmf_lo [PMF_WORDS];
    logic [15:0] pmf_q;

    logic                       wr, pmf_hit, obm_hit;
    logic [VRAM_ADDR_WIDTH-1:0] pmf_off, obm_off;

    assign wr      = write_enable && writable;
    assign pmf_off = address - VRAM_ADDR_WIDTH'(PMF_BASE);
    assign obm_off = address - VRAM_ADDR_WIDTH'(OBM_BASE);
    assign pmf_hit = (address >= VRAM_ADDR_WIDTH'(PMF_BASE)) && (pmf_off < VRAM_ADDR_WIDTH'(NUM_PATTERNS * 16));
    assign obm_hit = (address >= VRAM_ADDR_WIDTH'(OBM_BASE)) && (obm_off < VRAM_ADDR_WIDTH'(NUM_OBJECTS * 4));

    fg_state_t        state;
    logic             active_sel;
    logic             build_sel;
    logic [1:0]       ovf;
    fg_slot_t         bank [2][MAX_PER_LINE];
    fg_slot_t         active_slots [MAX_PER_LINE];
    logic [7:0]       target_y;
    logic [OBJ_W-1:0] obj;
    logic [SLOT_W-1:0] slot_cnt, fetch_idx;
    logic [2:0]       rec_row   [MAX_PER_LINE];
    logic [PAT_W-1:0] rec_pmfa  [MAX_PER_LINE];
    logic             rec_hflip [MAX_PER_LINE];
    logic             cap_pending, cap_hflip;
    logic [SI_W-1:0]  cap_idx;
    logic [PAT_W+2:0] rd_addr;

    logic [7:0] obj_x, obj_y;
    logic [6:0] obj_attr;
    logic [2:0] obj_col, obj_row;
    logic [8:0] dy;
    logic       hit;

    assign build_sel = ~active_sel;
    assign obj_x     = obm_x[obj];
    assign obj_y     = obm_y[obj];
    assign obj_attr  = obm_a[obj];
    assign obj_col   = obm_c[obj];
    assign dy        = {1'b0, target_y} - {1'b0, obj_y};
    assign hit       = dy < 9'd8;
    assign obj_row   = obj_attr[5] ? (3'd7 - dy[2:0]) : dy[2:0];
    assign rd_addr   = {rec_pmfa[fetch_idx[SI_W-1:0]], rec_row[fetch_idx[SI_W-1:0]]};

    // VRAM is never reset; PMF read is registered every cycle and only consumed in FETCH.
    always_ff @(posedge clk) begin
        if (wr && obm_hit) begin
            case (obm_off[1:0])
                2'd0:    obm_x[obm_off[OBJ_W+1:2]] <= data_in;
                2'd1:    obm_y[obm_off[OBJ_W+1:2]] <= data_in;
                2'd2:    obm_a[obm_off[OBJ_W+1:2]] <= data_in[6:0];
                default: obm_c[obm_off[OBJ_W+1:2]] <= data_in[2:0];
            endcase
        end
        if (wr && pmf_hit) begin
            if (pmf_off[0]) pmf_lo[pmf_off[PAT_W+3:1]] <= data_in;
            else            pmf_hi[pmf_off[PAT_W+3:1]] <= data_in;
        end
        pmf_q <= {pmf_hi[rd_addr], pmf_lo[rd_addr]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_sel  <= 1'b0;
            ovf         <= 2'b00;
            target_y    <= '0;
            obj         <= '0;
            slot_cnt    <= '0;
            fetch_idx   <= '0;
            cap_pending <= 1'b0;
            cap_hflip   <= 1'b0;
            cap_idx     <= '0;
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < MAX_PER_LINE; i++)
                    bank[s][i] <= '0;
        end else if (line_start) begin
            // Also the abort path: slots already fetched keep their valid bit.
            active_sel  <= build_sel;
            ovf[active_sel] <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++)
                bank[active_sel][i].valid <= 1'b0;
            target_y    <= current_y + 8'd1;
            obj         <= '0;
            slot_cnt    <= '0;
            cap_pending <= 1'b0;
            state       <= SCAN;
        end else begin
            case (state)
                SCAN: begin
                    if (hit) begin
                        if (slot_cnt < SLOT_W'(MAX_PER_LINE)) begin
                            bank[build_sel][slot_cnt[SI_W-1:0]].x      <= obj_x;
                            bank[build_sel][slot_cnt[SI_W-1:0]].colour <= obj_col;
                            rec_row[slot_cnt[SI_W-1:0]]   <= obj_row;
                            rec_pmfa[slot_cnt[SI_W-1:0]]  <= obj_attr[PAT_W-1:0];
                            rec_hflip[slot_cnt[SI_W-1:0]] <= obj_attr[6];
                            slot_cnt <= slot_cnt + 1'b1;
                        end else begin
                            ovf[build_sel] <= 1'b1;
                        end
                    end
                    if (obj == OBJ_W'(NUM_OBJECTS - 1)) begin
                        fetch_idx <= '0;
                        state     <= (slot_cnt == '0 && !hit) ? IDLE : FETCH;
                    end
                    obj <= obj + 1'b1;
                end
                FETCH: begin
                    if (cap_pending) begin
                        bank[build_sel][cap_idx].line  <= cap_hflip ? pair_reverse(pmf_q) : pmf_q;
                        bank[build_sel][cap_idx].valid <= 1'b1;
                    end
                    if (fetch_idx < slot_cnt) begin
                        cap_idx     <= fetch_idx[SI_W-1:0];
                        cap_hflip   <= rec_hflip[fetch_idx[SI_W-1:0]];
                        cap_pending <= 1'b1;
                        fetch_idx   <= fetch_idx + 1'b1;
                    end else begin
                        cap_pending <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_PER_LINE; i++)
            active_slots[i] = bank[active_sel][i];
    end

    assign busy            = (state != IDLE);
    assign sprite_overflow = ovf[active_sel];

    foreground_slot_mixer #(.MAX_PER_LINE(MAX_PER_LINE)) u_mixer (
        .current_x (current_x),
        .slots     (active_slots),
        .r         (r),
        .g         (g),
        .b         (b),
        .valid     (valid)
    );

endmodule

// File: tb/tb_foreground_scanline.sv
// Directed bench for foreground_scanline; pixel expectations are packed as {valid, r, g, b}.
module tb_foreground_scanline;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  current_x, current_y;
    logic        line_start, writable, write_enable;
    logic [7:0]  data_in;
    logic [11:0] address;
    logic [1:0]  r, g, b;
    logic        valid, busy, sprite_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    foreground_scanline dut (
        .clk             (clk),
        .rst             (rst),
        .current_x       (current_x),
        .current_y       (current_y),
        .line_start      (line_start),
        .writable        (writable),
        .data_in         (data_in),
        .address         (address),
        .write_enable    (write_enable),
        .r               (r),
        .g               (g),
        .b               (b),
        .valid           (valid),
        .busy            (busy),
        .sprite_overflow (sprite_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic vram_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic pat_row(input int p, input int row, input logic [15:0] w);
        vram_write(12'(p * 16 + row * 2), w[15:8]);
        vram_write(12'(p * 16 + row * 2 + 1), w[7:0]);
    endtask

    task automatic obj_set(input int idx, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] attr, input logic [7:0] col);
        vram_write(12'(12'h800 + idx * 4), x);
        vram_write(12'(12'h800 + idx * 4 + 1), y);
        vram_write(12'(12'h800 + idx * 4 + 2), attr);
        vram_write(12'(12'h800 + idx * 4 + 3), col);
    endtask

    task automatic pulse_line(input logic [7:0] y);
        @(negedge clk);
        current_y  = y;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("eval_done", busy, 1'b0);
    endtask

    // Evaluate line l, then make it the displayed line.
    task automatic show_line(input logic [7:0] l);
        pulse_line(l - 8'd1);
        wait_idle();
        pulse_line(l);
    endtask

    task automatic px(input string tag, input logic [7:0] x, input logic [6:0] exp);
        @(negedge clk);
        current_x = x;
        #1;
        check(tag, {valid, r, g, b}, exp);
    endtask

    task automatic no_x(input string tag);
        check(tag, $isunknown({r, g, b, valid, busy, sprite_overflow}), 1'b0);
    endtask

    initial begin
        rst = 1'b1; current_x = '0; current_y = '0; line_start = 1'b0;
        writable = 1'b1; write_enable = 1'b0; data_in = '0; address = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pixel", {valid, r, g, b}, 7'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", sprite_overflow, 1'b0);

        for (int a = 0; a < 512; a++) vram_write(12'(a), 8'h00);
        for (int i = 0; i < 64; i++) obj_set(i, 8'd0, 8'd200, 8'h00, 8'h00);

        // Basic placement and horizontal extent
        pat_row(1, 0, 16'h4000);
        obj_set(0, 8'd10, 8'd20, 8'h01, 8'h04);
        show_line(8'd20);
        check("busy_eval", busy, 1'b1);
        px("basic_x10", 8'd10, 7'b1010000);
        px("basic_x9", 8'd9, 7'b0000000);
        px("basic_x11", 8'd11, 7'b0000000);

        // Priority: lower OBM index wins while opaque
        pat_row(2, 0, 16'hC000);
        pat_row(3, 0, 16'hC000);
        obj_set(3, 8'd30, 8'd40, 8'h02, 8'h02);
        obj_set(5, 8'd30, 8'd40, 8'h03, 8'h01);
        show_line(8'd40);
        px("prio_obj3", 8'd30, 7'b1001100);
        @(negedge clk);
        writable = 1'b0;
        vram_write(12'h020, 8'h00);
        writable = 1'b1;
        show_line(8'd40);
        px("prio_not_writable", 8'd30, 7'b1001100);
        vram_write(12'h020, 8'h00);
        show_line(8'd40);
        px("prio_obj5", 8'd30, 7'b1000011);

        // Per-line limit: 20..27 at Y=50, 28..29 at Y=43 (bottom row on line 50)
        for (int r0 = 0; r0 < 8; r0++) pat_row(4, r0, 16'h4000);
        for (int k = 0; k < 10; k++)
            obj_set(20 + k, 8'(60 + 10 * k), (k < 8) ? 8'd50 : 8'd43, 8'h04, 8'h07);
        show_line(8'd50);
        check("ovf_line50", sprite_overflow, 1'b1);
        for (int k = 0; k < 10; k++)
            px($sformatf("limit_k%0d", k), 8'(60 + 10 * k), (k < 8) ? 7'b1010101 : 7'b0000000);
        show_line(8'd51);
        check("ovf_line51", sprite_overflow, 1'b0);
        px("line51_x60", 8'd60, 7'b1010101);
        px("line51_x130", 8'd130, 7'b1010101);

        // hflip + vflip: top-left pixel shows pattern row 7, column 7
        pat_row(5, 7, 16'h8001);
        pat_row(5, 6, 16'h0002);
        obj_set(30, 8'd80, 8'd100, 8'h65, 8'h07);
        show_line(8'd100);
        px("flip_x80", 8'd80, 7'b1010101);
        px("flip_x81", 8'd81, 7'b0000000);
        px("flip_x87", 8'd87, 7'b1101010);

        // Edges: no vertical wrap from Y=0xFF, no horizontal wrap from X=0xFC
        for (int r0 = 0; r0 < 8; r0++) pat_row(6, r0, 16'h5555);
        obj_set(31, 8'hFC, 8'hFF, 8'h06, 8'h04);
        show_line(8'd255);
        px("edge_x252", 8'd252, 7'b1010000);
        px("edge_x255", 8'd255, 7'b1010000);
        px("edge_x251", 8'd251, 7'b0000000);
        px("edge_x0", 8'd0, 7'b0000000);
        show_line(8'd0);
        px("edge_line0", 8'd252, 7'b0000000);
        show_line(8'd6);
        px("edge_line6", 8'd253, 7'b0000000);

        // Abort mid-SCAN: new line shows no unfetched slots, then restarts
        pulse_line(8'd99);
        repeat (20) @(negedge clk);
        pulse_line(8'd100);
        check("abort_busy", busy, 1'b1);
        px("abort_x80", 8'd80, 7'b0000000);
        no_x("abort_no_x");
        wait_idle();
        pulse_line(8'd101);
        px("restart_line101", 8'd80, 7'b1101010);

        // Reset mid-FETCH of an 8-slot line
        pulse_line(8'd49);
        repeat (68) @(negedge clk);
        check("busy_pre_rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        no_x("rst_no_x");
        check("rst2_valid", valid, 1'b0);
        check("rst2_busy", busy, 1'b0);
        check("rst2_ovf", sprite_overflow, 1'b0);
        show_line(8'd100);
        px("post_rst_x80", 8'd80, 7'b1010101);
        no_x("post_rst_no_x");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/foreground_scanline.md
Name: foreground_scanline

Overview:
- Next-generation foreground (sprite) engine for the GPU.
- Replaces per-pixel evaluation of every object with a per-line evaluation FSM and double-banked line-slot registers.
- Supports a parametrised object count and a per-line sprite limit with overflow reporting.
- Sits beside the background block and feeds the pixel mixer; shares the VRAM write bus and video timing counters.

Parameters:
- NUM_OBJECTS, 64, objects held in OBM (4 bytes each); max 64.
- MAX_PER_LINE, 8, sprite slots evaluated per scanline; 1..16.
- NUM_PATTERNS, 32, 8x8 2bpp patterns in PMF (16 bytes each).

Ports:
- clk  in  1  pixel clock (12.5875 MHz)
- rst  in  1  synchronous, active-high reset
- current_x  in  8  visible pixel column
- current_y  in  8  visible line
- line_start  in  1  one-cycle pulse at start of each line; current_y is already the new line
- writable  in  1  VRAM write permitted
- data_in  in  8  VRAM write data
- address  in  VRAM_ADDR_WIDTH  VRAM write address
- write_enable  in  1  VRAM write strobe
- r, g, b  out  2 each  foreground colour
- valid  out  1  foreground pixel opaque
- busy  out  1  evaluation of next line in progress
- sprite_overflow  out  1  more than MAX_PER_LINE objects hit the displayed line

Behaviour:
- Memory map:
  - PMF at 0x000..(NUM_PATTERNS*16-1).
  - OBM at 0x800..(0x800+NUM_OBJECTS*4-1).
  - Writes occur when write_enable && writable; other addresses are ignored.
  - Memories are not reset.
- Object byte layout:
  - byte0 = X, byte1 = Y.
  - byte2 = {-, hflip, vflip, pmfa[4:0]}.
  - byte3[2:0] = colour {r, g, b}.
- Two slot banks, active and build. Each slot holds valid, x[7:0], line[15:0] (already h-flipped) and colour[2:0].
- FSM states and transitions:
  - IDLE: on line_start, swap banks, clear all build-bank valid bits, target_y <= current_y + 1 (8-bit wrap), obj <= 0, slot_cnt <= 0, go to SCAN.
  - SCAN: examine one object per cycle.
    - Hit if {1'b0, target_y} - {1'b0, Y} < 9'd8, using 9-bit unsigned arithmetic, so there is no wrap. A Y of 0xF9..0xFF never reaches line 0.
    - On a hit with slot_cnt < MAX_PER_LINE, record x, row = vflip ? 7-dy : dy, pmfa, hflip, colour in slot[slot_cnt] and increment slot_cnt.
    - On a hit with slot_cnt == MAX_PER_LINE, set build-bank overflow and ignore the object.
    - After obj == NUM_OBJECTS-1, go to FETCH with fetch index 0.
  - FETCH: one synchronous PMF read per slot, 16 bits at {pmfa, row}, with 1-cycle read latency.
    - Data lands in the slot the following cycle. If hflip is set, 2-bit pixel pairs are reversed.
    - Go to IDLE after the last recorded slot's data is captured. With zero slots, go directly to IDLE.
- Worst-case evaluation length is NUM_OBJECTS + MAX_PER_LINE + 2 cycles; it must be shorter than the line period.
- line_start while not IDLE:
  - Abort the current evaluation.
  - Slots whose fetch completed stay valid; slots without fetched data are invalidated.
  - Swap banks and restart for the new target_y.
- busy = (state != IDLE).
- Rendering is combinational from the active bank, so there is zero latency relative to current_x. For each valid slot:
  - dx = {1'b0, current_x} - {1'b0, x}.
  - The slot hits if dx < 8.
  - pix = line[{3'd7 - dx[2:0], 1'b0} +: 2].
  - The slot is opaque if it hits and pix != 0.
- The lowest-index opaque slot wins, which is also the lowest OBM index. Outputs:
  - r = pix & {2{c[2]}}, likewise g and b.
  - valid = any slot opaque.
  - When no slot is opaque, r, g, b = 0 and valid = 0.
- sprite_overflow is the active bank's flag, updated at each swap.
- Reset (synchronous):
  - state = IDLE.
  - Both banks' valid bits and overflow flags cleared.
  - valid, busy, sprite_overflow = 0; r, g, b = 0.
  - Reset mid-evaluation discards all slots.
- VRAM writes during SCAN or FETCH take effect for any object or pattern read after the write cycle. No stall occurs.

Decomposition:
- Package gpu_fg_pkg holds:
  - PMF_BASE and OBM_BASE constants.
  - fg_slot_t struct (valid, x, line, colour).
  - fg_state_t enum {IDLE, SCAN, FETCH}.
  - An hflip pair-reverse function.
- Sub-module foreground_slot_mixer: a purely combinational per-slot hit test plus priority encoder (ffs) over the MAX_PER_LINE slots, producing r, g, b and valid.

Test Plan:
- Object 0 at X=10, Y=20, pmfa 1, colour 3'b100, pattern row 0 = 16'h4000; line_start with current_y=19, then line_start with current_y=20 -> at x=10, r=2'b01, g=b=0, valid=1; at x=9 and x=11, valid=0.
- Objects 3 and 5 overlapping at the same X/Y with different colours -> object 3's colour is output; clear object 3's pixel to 0 -> object 5's colour shows through.
- 10 objects on line 50 with MAX_PER_LINE=8 -> objects 0..7 render, 8 and 9 are absent, sprite_overflow=1 while line 50 displays and returns to 0 on line 51.
- Object hflip=1 and vflip=1 with an asymmetric pattern -> the pixel at (X, Y) equals pattern row 7, column 7.
- Object at Y=0xFF -> renders only on line 255, never on lines 0..6. Object at X=0xFC -> columns 252..255 only, with no wrap to column 0.
- line_start pulsed 20 cycles after the previous one (mid-SCAN), and rst asserted mid-FETCH -> no X on outputs; after rst, valid=0, busy=0, and the next full line evaluates correctly.
